// File: rtl/nibble_serial_adder_ctrl_pkg.sv
// Shared definitions for the nibble-serial adder sequencer: state encoding,
// default operand width and the nibble-counter width helper.
// Pure declarations; no logic, no latency, no backpressure.
package nibble_serial_adder_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int DEFAULT_WIDTH = 16;

  // Counter width for stepping through nib nibbles; never narrower than 1 bit.
  function automatic int cnt_width(input int nib);
    return (nib <= 2) ? 1 : $clog2(nib);
  endfunction

endpackage

// File: rtl/full_adder_4bit.sv
// 4-bit ripple adder used as the shared nibble datapath.
// Latency: purely combinational.
// Backpressure: none.
module full_adder_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);

  // Five-bit sum so the carry-out falls out of the top bit.
  assign {co, s} = {1'b0, a} + {1'b0, b} + {4'b0000, ci};

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// WIDTH-bit add/subtract computed one nibble per clock through one 4-bit adder.
// Latency: done pulses in the cycle after the NIB-th RUN edge following the start edge.
// Backpressure: start is ignored while busy; no queuing of requests.
module nibble_serial_adder_ctrl
  import nibble_serial_adder_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);

  localparam int NIB = WIDTH / 4;
  localparam int CW  = cnt_width(NIB);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, b_sr_q, res_q;
  logic [WIDTH-1:0] a_sr_d, b_sr_d, res_d;
  logic [CW-1:0]    cnt_q;
  logic             cy_q;
  logic             a_msb_q, bx_msb_q;
  logic [WIDTH-1:0] sum_q;
  logic             c_out_q, ovf_q;

  logic             accept;
  logic             last;
  logic [3:0]       nib_sum;
  logic             nib_co;

  // A request is taken whenever no operation is running, including the DONE cycle.
  assign accept = start && (state_q != ST_RUN);
  assign last   = (cnt_q == CW'(NIB - 1));

  full_adder_4bit u_nib_adder (
    .a  (a_sr_q[3:0]),
    .b  (b_sr_q[3:0]),
    .ci (cy_q),
    .s  (nib_sum),
    .co (nib_co)
  );

  // Shift next-values: operands move right, result fills from the MSB end.
  always_comb begin
    a_sr_d = {4'b0000, a_sr_q[WIDTH-1:4]};
    b_sr_d = {4'b0000, b_sr_q[WIDTH-1:4]};
    res_d  = {nib_sum, res_q[WIDTH-1:4]};
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic: RUN for NIB cycles, a single DONE cycle, then back to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_RUN;
      ST_RUN:  if (last)  state_d = ST_DONE;
      ST_DONE: state_d = start ? ST_RUN : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath: load operands on accept, step one nibble per RUN cycle, publish at the end.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      res_q    <= '0;
      cnt_q    <= '0;
      cy_q     <= 1'b0;
      a_msb_q  <= 1'b0;
      bx_msb_q <= 1'b0;
      sum_q    <= '0;
      c_out_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else if (accept) begin
      // Subtraction is A + ~B + 1; the +1 rides in on the initial carry.
      a_sr_q   <= a;
      b_sr_q   <= sub ? ~b : b;
      cy_q     <= sub ? 1'b1 : c_in;
      cnt_q    <= '0;
      a_msb_q  <= a[WIDTH-1];
      bx_msb_q <= sub ? ~b[WIDTH-1] : b[WIDTH-1];
    end else if (state_q == ST_RUN) begin
      a_sr_q <= a_sr_d;
      b_sr_q <= b_sr_d;
      res_q  <= res_d;
      cy_q   <= nib_co;
      cnt_q  <= cnt_q + CW'(1);
      if (last) begin
        sum_q   <= res_d;
        c_out_q <= nib_co;
        ovf_q   <= (a_msb_q == bx_msb_q) && (res_d[WIDTH-1] != a_msb_q);
      end
    end
  end

  assign busy  = (state_q == ST_RUN);
  assign done  = (state_q == ST_DONE);
  assign sum   = sum_q;
  assign c_out = c_out_q;
  assign ovf   = ovf_q;

endmodule
